apb_spi_fifo: RTL and testbench
===============================

Name: apb_spi_fifo

Overview:
APB3 slave SPI master. It is the parametrised successor of the single-byte SPI peripheral, with configurable word width, TX/RX FIFOs, NUM_CS chip selects, LSB-first mode and a masked multi-source IRQ. It sits on the APB peripheral bus next to the other N5 IPs; one SPI bus drives up to NUM_CS devices.

Parameters:
DATA_W, 8, SPI word width in bits; 4..32.
FIFO_DEPTH, 4, entries per TX and RX FIFO; power of 2, at least 2.
NUM_CS, 2, number of active-low chip selects; 1..8.
CLKDIV_W, 8, width of the SCLK divider field; at most 16.

Ports:
PCLK  in  1  bus and core clock; single clock domain.
PRESETn  in  1  asynchronous active-low reset.
PSEL, PENABLE, PWRITE  in  1 each  APB controls.
PADDR  in  32  only [4:2] decoded.
PWDATA  in  32  write data.
PRDATA  out  32  read data, combinational.
PREADY  out  1  tied 1, zero wait states.
MSI  in  1  serial data from slave.
MSO  out  1  serial data to slave.
SCLK  out  1  SPI clock.
SSn  out  NUM_CS  chip selects, active low.
IRQ  out  1  level interrupt.

Behaviour:
- Write strobe is PSEL&PENABLE&PWRITE. Read strobe is PSEL&PENABLE&~PWRITE. Unused register bits read 0.
- 0x00 DATA
  - Write pushes PWDATA[DATA_W-1:0] into the TX FIFO; the write is dropped if TX is full.
  - Read returns the RX head, zero-extended, and pops once per access. Reading an empty RX returns 0 and does not pop.
- 0x04 CTRL (RW)
  - bit0 EN.
  - [8+NUM_CS-1:8] CS: SSn[i] = ~CS[i]. CS is fully software-controlled and never touched by the engine.
- 0x08 CFG (RW)
  - bit0 CPOL, bit1 CPHA, bit2 LSBF.
  - [16+CLKDIV_W-1:16] DIV.
  - Writes while busy are ignored.
- 0x0C STATUS (R)
  - bit0 busy, bit1 tx_empty, bit2 tx_full, bit3 rx_empty, bit4 rx_full, bit5 rx_ovf.
  - rx_ovf is sticky; writing 1 to bit5 clears it.
- 0x10 IM (RW): bit0 tx_empty, bit1 rx_not_empty, bit2 rx_ovf.
- Offsets 0x14-0x1C read 0; writes ignored.
- IRQ = (IM0&tx_empty) | (IM1&~rx_empty) | (IM2&rx_ovf), registered-source level.
- Reset state: all registers 0, FIFOs empty, FSM IDLE.
  - Outputs at reset: SCLK=0, MSO=0, SSn all 1, IRQ=0, busy=0.
- SCLK idles at CPOL.
  - Half period = DIV+1 PCLK cycles, so DIV=0 gives SCLK = PCLK/2.
  - A word takes 2*DATA_W half periods.
- FSM states:
  - IDLE: if EN & ~tx_empty, pop TX into the shift register and go to LOAD. busy is 1 from the cycle after the pop.
  - LOAD: one cycle. Drive the first bit on MSO (MSB, or LSB if LSBF). Go to SHIFT.
  - SHIFT: on each half-period expiry SCLK toggles. Edge 1 is leading.
    - CPHA=0: sample MSI on leading edges, shift MSO on trailing edges.
    - CPHA=1: shift on leading edges, sample on trailing edges.
    - After edge 2*DATA_W, go to DONE.
  - DONE: one cycle.
    - Push the received word to RX. If RX is full, drop the word and set rx_ovf.
    - If EN & ~tx_empty, pop TX and go to LOAD (back-to-back, SCLK stays at CPOL). Otherwise go to IDLE and clear busy.
- Clearing EN mid-word finishes the current word, then stops. TX contents are kept.
- A simultaneous APB push to a full TX and an engine pop in the same cycle is accepted: the pop frees the slot.
- Simultaneous push and pop on RX are both performed; count is unchanged.
- An APB rx_ovf clear and a new overflow in the same cycle: overflow wins (bit stays 1).
- Asynchronous reset mid-word aborts immediately to the reset state. Partial data is lost.

Test Plan:
- Reset: check PRDATA reads of STATUS=0x0A (tx_empty, rx_empty), SSn=all 1, SCLK=0, IRQ=0.
- Loopback (MSO tied to MSI), DATA_W=8, DIV=1, CPOL=0, CPHA=0, CS=0x1, EN=1; write 0xA5 then 0x3C -> SSn[0]=0; 16 SCLK rising edges, 4 PCLK per period; RX reads return 0xA5 then 0x3C; busy then drops and tx_empty=1.
- Modes: for all four CPOL/CPHA combinations and LSBF=1, send 0x81 to a bench SPI slave model returning 0x5A -> slave receives 0x81 (LSB-first on the wire), RX reads 0x5A, and SCLK idle level equals CPOL.
- Overflow: FIFO_DEPTH=4, no RX reads, push 6 words -> RX holds the first 4, rx_ovf=1; IRQ rises only once IM bit2 is set; writing STATUS 0x20 clears rx_ovf and IRQ.
- TX full: EN=0, write 5 words -> tx_full=1; 5th write dropped; EN=1 -> exactly 4 words transmitted back-to-back with no SCLK gap beyond the LOAD/DONE cycles.
- Abort: assert PRESETn=0 mid-word (after edge 5) -> SCLK=0 and busy=0 immediately; FIFOs empty; after release a new word transfers correctly.

Source files
------------

// File: rtl/apb_spi_fifo.sv
`default_nettype none
// ---------------------------------------------------------------------------
// apb_spi_fifo: APB3 slave SPI master with TX/RX FIFOs, software chip
// selects, CPOL/CPHA/LSB-first modes and a masked level interrupt.  Rev 1.0
// ---------------------------------------------------------------------------
module apb_spi_fifo #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int NUM_CS     = 2,
  parameter int CLKDIV_W   = 8
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [31:0]       PADDR,
  input  logic [31:0]       PWDATA,
  output logic [31:0]       PRDATA,
  output logic              PREADY,
  input  logic              MSI,
  output logic              MSO,
  output logic              SCLK,
  output logic [NUM_CS-1:0] SSn,
  output logic              IRQ
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int EW = $clog2(2*DATA_W+1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_DONE} state_t;

  logic       wr_stb, rd_stb;
  logic [2:0] addr;
  assign wr_stb = PSEL & PENABLE & PWRITE;
  assign rd_stb = PSEL & PENABLE & ~PWRITE;
  assign addr   = PADDR[4:2];

  logic                en_q, cpol_q, cpha_q, lsbf_q, ovf_q, busy_q;
  logic [NUM_CS-1:0]   cs_q;
  logic [CLKDIV_W-1:0] div_q;
  logic [2:0]          im_q;

  logic [DATA_W-1:0] tx_mem [FIFO_DEPTH];
  logic [DATA_W-1:0] rx_mem [FIFO_DEPTH];
  logic [AW-1:0]     tx_wp_q, tx_rp_q, rx_wp_q, rx_rp_q;
  logic [AW:0]       tx_cnt_q, rx_cnt_q;

  state_t              state_q;
  logic                sclk_q, mso_q;
  logic [DATA_W-1:0]   tx_sh_q, rx_sh_q;
  logic [CLKDIV_W-1:0] div_cnt_q;
  logic [EW-1:0]       edge_cnt_q;

  logic tx_empty, tx_full, rx_empty, rx_full;
  logic tx_pop, tx_push, rx_pop, rx_push, rx_in, ovf_set, ovf_clr, eng_start;
  assign tx_empty = (tx_cnt_q == '0);
  assign tx_full  = (tx_cnt_q == (AW+1)'(FIFO_DEPTH));
  assign rx_empty = (rx_cnt_q == '0);
  assign rx_full  = (rx_cnt_q == (AW+1)'(FIFO_DEPTH));

  // The engine pops in IDLE or DONE; a pop in the same cycle frees a slot for a push.
  assign eng_start = en_q & ~tx_empty & ((state_q == S_IDLE) | (state_q == S_DONE));
  assign tx_pop    = eng_start;
  assign tx_push   = wr_stb & (addr == 3'd0) & (~tx_full | tx_pop);
  assign rx_pop    = rd_stb & (addr == 3'd0) & ~rx_empty;
  assign rx_in     = (state_q == S_DONE);
  assign rx_push   = rx_in & (~rx_full | rx_pop);
  assign ovf_set   = rx_in & rx_full & ~rx_pop;
  assign ovf_clr   = wr_stb & (addr == 3'd3) & PWDATA[5];

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      en_q   <= 1'b0;
      cs_q   <= '0;
      cpol_q <= 1'b0;
      cpha_q <= 1'b0;
      lsbf_q <= 1'b0;
      div_q  <= '0;
      im_q   <= '0;
      ovf_q  <= 1'b0;
    end else begin
      if (wr_stb && addr == 3'd1) begin
        en_q <= PWDATA[0];
        cs_q <= PWDATA[8 +: NUM_CS];
      end
      if (wr_stb && addr == 3'd2 && !busy_q) begin
        cpol_q <= PWDATA[0];
        cpha_q <= PWDATA[1];
        lsbf_q <= PWDATA[2];
        div_q  <= PWDATA[16 +: CLKDIV_W];
      end
      if (wr_stb && addr == 3'd4) im_q <= PWDATA[2:0];
      ovf_q <= ovf_set | (ovf_q & ~ovf_clr);
    end
  end

  always_ff @(posedge PCLK) begin
    if (tx_push) tx_mem[tx_wp_q] <= PWDATA[DATA_W-1:0];
    if (rx_push) rx_mem[rx_wp_q] <= rx_sh_q;
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      tx_wp_q  <= '0;
      tx_rp_q  <= '0;
      tx_cnt_q <= '0;
      rx_wp_q  <= '0;
      rx_rp_q  <= '0;
      rx_cnt_q <= '0;
    end else begin
      if (tx_push) tx_wp_q <= tx_wp_q + 1'b1;
      if (tx_pop)  tx_rp_q <= tx_rp_q + 1'b1;
      if (tx_push && !tx_pop) tx_cnt_q <= tx_cnt_q + 1'b1;
      else if (!tx_push && tx_pop) tx_cnt_q <= tx_cnt_q - 1'b1;
      if (rx_push) rx_wp_q <= rx_wp_q + 1'b1;
      if (rx_pop)  rx_rp_q <= rx_rp_q + 1'b1;
      if (rx_push && !rx_pop) rx_cnt_q <= rx_cnt_q + 1'b1;
      else if (!rx_push && rx_pop) rx_cnt_q <= rx_cnt_q - 1'b1;
    end
  end

  logic              tick, sample, first_edge, last_edge, next_bit;
  logic [EW-1:0]     edge_n;
  logic [DATA_W-1:0] tx_shifted;
  assign tick       = (div_cnt_q == div_q);
  assign edge_n     = edge_cnt_q + 1'b1;
  assign sample     = edge_n[0] ^ cpha_q;
  assign first_edge = (edge_n == EW'(1));
  assign last_edge  = (edge_n == EW'(2*DATA_W));
  assign next_bit   = lsbf_q ? tx_sh_q[0] : tx_sh_q[DATA_W-1];
  assign tx_shifted = lsbf_q ? (tx_sh_q >> 1) : (tx_sh_q << 1);

  // With CPHA=1 the first bit is already on MSO from LOAD, so edge 1 does not shift.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q    <= S_IDLE;
      busy_q     <= 1'b0;
      sclk_q     <= 1'b0;
      mso_q      <= 1'b0;
      tx_sh_q    <= '0;
      rx_sh_q    <= '0;
      div_cnt_q  <= '0;
      edge_cnt_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          sclk_q <= cpol_q;
          if (eng_start) begin
            tx_sh_q <= tx_mem[tx_rp_q];
            busy_q  <= 1'b1;
            state_q <= S_LOAD;
          end
        end
        S_LOAD: begin
          mso_q      <= next_bit;
          tx_sh_q    <= tx_shifted;
          div_cnt_q  <= '0;
          edge_cnt_q <= '0;
          state_q    <= S_SHIFT;
        end
        S_SHIFT: begin
          if (tick) begin
            div_cnt_q  <= '0;
            sclk_q     <= ~sclk_q;
            edge_cnt_q <= edge_n;
            if (sample) begin
              rx_sh_q <= lsbf_q ? {MSI, rx_sh_q[DATA_W-1:1]} : {rx_sh_q[DATA_W-2:0], MSI};
            end else if (!(cpha_q && first_edge)) begin
              mso_q   <= next_bit;
              tx_sh_q <= tx_shifted;
            end
            if (last_edge) state_q <= S_DONE;
          end else begin
            div_cnt_q <= div_cnt_q + 1'b1;
          end
        end
        S_DONE: begin
          if (eng_start) begin
            tx_sh_q <= tx_mem[tx_rp_q];
            state_q <= S_LOAD;
          end else begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    PRDATA = '0;
    case (addr)
      3'd0: if (!rx_empty) PRDATA[DATA_W-1:0] = rx_mem[rx_rp_q];
      3'd1: begin
        PRDATA[0]            = en_q;
        PRDATA[8 +: NUM_CS]  = cs_q;
      end
      3'd2: begin
        PRDATA[0]             = cpol_q;
        PRDATA[1]             = cpha_q;
        PRDATA[2]             = lsbf_q;
        PRDATA[16 +: CLKDIV_W] = div_q;
      end
      3'd3: PRDATA[5:0] = {ovf_q, rx_full, rx_empty, tx_full, tx_empty, busy_q};
      3'd4: PRDATA[2:0] = im_q;
      default: PRDATA = '0;
    endcase
  end

  logic unused_ok;
  assign unused_ok = ^{PADDR, PWDATA};

  assign PREADY = 1'b1;
  assign SCLK   = sclk_q;
  assign MSO    = mso_q;
  assign SSn    = ~cs_q;
  assign IRQ    = (im_q[0] & tx_empty) | (im_q[1] & ~rx_empty) | (im_q[2] & ovf_q);

endmodule
`default_nettype wire

// File: tb/tb_apb_spi_fifo.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_apb_spi_fifo: directed bench for apb_spi_fifo with loopback and an SPI
// slave model.  Rev 1.0
// ---------------------------------------------------------------------------
module tb_apb_spi_fifo;

  localparam logic [31:0] A_DATA = 32'h00, A_CTRL = 32'h04, A_CFG = 32'h08,
                          A_STAT = 32'h0C, A_IM = 32'h10;

  logic        PCLK = 1'b0, PRESETn = 1'b0;
  logic        PSEL = 1'b0, PENABLE = 1'b0, PWRITE = 1'b0;
  logic [31:0] PADDR = '0, PWDATA = '0;
  logic [31:0] PRDATA;
  logic        PREADY, MSO, SCLK, IRQ;
  logic [1:0]  SSn;
  logic        loop_mode = 1'b1;
  logic        s_miso = 1'b0;
  logic        msi_w;

  assign msi_w = loop_mode ? MSO : s_miso;

  apb_spi_fifo #(.DATA_W(8), .FIFO_DEPTH(4), .NUM_CS(2), .CLKDIV_W(8)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY),
    .MSI(msi_w), .MSO(MSO), .SCLK(SCLK), .SSn(SSn), .IRQ(IRQ)
  );

  always #5 PCLK = ~PCLK;

  int total = 0, bad = 0;
  int cyc = 0, rise_n = 0, tog = 0;
  int rise_t [64];

  always @(posedge PCLK) cyc++;
  always @(posedge SCLK) begin
    if (rise_n < 64) rise_t[rise_n] = cyc;
    rise_n++;
  end
  always @(SCLK) tog++;

  // SPI slave model: mode follows s_cpha/s_lsbf, framed by edge count.
  logic       slave_on = 1'b0, s_cpha = 1'b0, s_lsbf = 1'b0;
  logic [7:0] s_tx = '0, s_rx = '0;
  int         s_edges = 0;

  always @(SCLK) begin
    if (slave_on) begin
      s_edges++;
      if ((s_edges % 2 == 1) ^ s_cpha) begin
        s_rx = s_lsbf ? {MSO, s_rx[7:1]} : {s_rx[6:0], MSO};
      end else if (!(s_cpha && s_edges == 1)) begin
        s_tx   = s_lsbf ? (s_tx >> 1) : (s_tx << 1);
        s_miso = s_lsbf ? s_tx[0] : s_tx[7];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic apb_wr(input logic [31:0] a, input logic [31:0] d);
    @(posedge PCLK); #1;
    PSEL = 1'b1; PWRITE = 1'b1; PADDR = a; PWDATA = d; PENABLE = 1'b0;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic apb_rd(input logic [31:0] a, output logic [31:0] d);
    @(posedge PCLK); #1;
    PSEL = 1'b1; PWRITE = 1'b0; PADDR = a; PENABLE = 1'b0;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    #2 d = PRDATA;
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] d;
    apb_rd(a, d);
    chk(tag, d, exp);
  endtask

  task automatic wait_idle(input string tag);
    logic [31:0] st;
    logic        ok;
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      apb_rd(A_STAT, st);
      if (st[0] == 1'b0 && st[1] == 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    chk(tag, {31'b0, ok}, 32'd1);
  endtask

  // DIV=1: rising edges 4 PCLK apart inside a word, 6 across a DONE/LOAD boundary.
  task automatic check_rises(input string tag, input int nwords);
    int bg;
    int ex;
    bg = 0;
    chk({tag, "_rises"}, rise_n, nwords * 8);
    for (int i = 1; i < nwords * 8; i++) begin
      ex = (i % 8 == 0) ? 6 : 4;
      if (rise_t[i] - rise_t[i-1] != ex) bg++;
    end
    chk({tag, "_gaps"}, bg, 0);
  endtask

  task automatic do_mode(input string tag, input logic cpol, input logic cpha,
                         input logic lsbf, input logic [7:0] mtx, input logic [7:0] stx);
    slave_on = 1'b0;
    apb_wr(A_CFG, 32'h0001_0000 | {29'b0, lsbf, cpha, cpol});
    repeat (3) @(posedge PCLK);
    #1 chk({tag, "_idle_sclk"}, {31'b0, SCLK}, {31'b0, cpol});
    s_tx = stx; s_rx = '0; s_edges = 0; s_cpha = cpha; s_lsbf = lsbf;
    s_miso = lsbf ? stx[0] : stx[7];
    slave_on = 1'b1;
    apb_wr(A_DATA, {24'b0, mtx});
    wait_idle({tag, "_idle"});
    chk({tag, "_slave_rx"}, {24'b0, s_rx}, {24'b0, mtx});
    rd_chk({tag, "_rx"}, A_DATA, {24'b0, stx});
    chk({tag, "_end_sclk"}, {31'b0, SCLK}, {31'b0, cpol});
    slave_on = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic ok;
    // Reset state
    repeat (3) @(posedge PCLK);
    #1 PRESETn = 1'b1;
    chk("rst_sclk", {31'b0, SCLK}, 32'd0);
    chk("rst_mso", {31'b0, MSO}, 32'd0);
    chk("rst_ssn", {30'b0, SSn}, 32'd3);
    chk("rst_irq", {31'b0, IRQ}, 32'd0);
    chk("rst_pready", {31'b0, PREADY}, 32'd1);
    rd_chk("rst_status", A_STAT, 32'h0A);
    rd_chk("rst_ctrl", A_CTRL, 32'h0);
    rd_chk("rst_empty_rd", A_DATA, 32'h0);

    // Loopback, two back-to-back words
    loop_mode = 1'b1;
    apb_wr(A_CFG, 32'h0001_0000);
    apb_wr(A_CTRL, 32'h0000_0101);
    rd_chk("cfg_rb", A_CFG, 32'h0001_0000);
    rd_chk("ctrl_rb", A_CTRL, 32'h0000_0101);
    chk("lb_ssn", {30'b0, SSn}, 32'd2);
    rise_n = 0;
    apb_wr(A_DATA, 32'hA5);
    apb_wr(A_DATA, 32'h3C);
    wait_idle("lb_idle");
    check_rises("lb", 2);
    rd_chk("lb_rx0", A_DATA, 32'hA5);
    rd_chk("lb_rx1", A_DATA, 32'h3C);
    rd_chk("lb_status", A_STAT, 32'h0A);

    // Modes against the slave model
    loop_mode = 1'b0;
    do_mode("m0", 1'b0, 1'b0, 1'b1, 8'h81, 8'h5A);
    do_mode("m1", 1'b1, 1'b0, 1'b1, 8'h81, 8'h5A);
    do_mode("m2", 1'b0, 1'b1, 1'b1, 8'h81, 8'h5A);
    do_mode("m3", 1'b1, 1'b1, 1'b1, 8'h81, 8'h5A);
    do_mode("msb", 1'b0, 1'b0, 1'b0, 8'h13, 8'hC4);
    do_mode("lsb", 1'b1, 1'b1, 1'b1, 8'h13, 8'hC4);

    // RX overflow and interrupt sources
    loop_mode = 1'b1;
    apb_wr(A_CFG, 32'h0000_0000);
    repeat (2) @(posedge PCLK);
    for (int i = 1; i <= 6; i++) apb_wr(A_DATA, 32'h11 * i);
    wait_idle("ovf_idle");
    rd_chk("ovf_status", A_STAT, 32'h32);
    chk("ovf_irq_masked", {31'b0, IRQ}, 32'd0);
    apb_wr(A_IM, 32'h4);
    chk("ovf_irq", {31'b0, IRQ}, 32'd1);
    apb_wr(A_STAT, 32'h20);
    rd_chk("ovf_clr_status", A_STAT, 32'h12);
    chk("ovf_clr_irq", {31'b0, IRQ}, 32'd0);
    apb_wr(A_IM, 32'h2);
    chk("rxne_irq", {31'b0, IRQ}, 32'd1);
    rd_chk("ovf_rx0", A_DATA, 32'h11);
    rd_chk("ovf_rx1", A_DATA, 32'h22);
    rd_chk("ovf_rx2", A_DATA, 32'h33);
    rd_chk("ovf_rx3", A_DATA, 32'h44);
    rd_chk("ovf_rx_empty", A_DATA, 32'h0);
    chk("rxne_irq_off", {31'b0, IRQ}, 32'd0);
    apb_wr(A_IM, 32'h1);
    chk("txe_irq", {31'b0, IRQ}, 32'd1);
    apb_wr(A_IM, 32'h0);

    // TX full, dropped write, back-to-back drain
    apb_wr(A_CTRL, 32'h0000_0100);
    apb_wr(A_CFG, 32'h0001_0000);
    for (int i = 1; i <= 5; i++) apb_wr(A_DATA, 32'hC0 + i);
    rd_chk("txf_status", A_STAT, 32'h0C);
    rise_n = 0;
    apb_wr(A_CTRL, 32'h0000_0101);
    wait_idle("txf_idle");
    check_rises("txf", 4);
    rd_chk("txf_rx0", A_DATA, 32'hC1);
    rd_chk("txf_rx1", A_DATA, 32'hC2);
    rd_chk("txf_rx2", A_DATA, 32'hC3);
    rd_chk("txf_rx3", A_DATA, 32'hC4);
    rd_chk("txf_rx_empty", A_DATA, 32'h0);
    rd_chk("txf_status_end", A_STAT, 32'h0A);

    // Asynchronous abort mid-word
    tog = 0;
    apb_wr(A_DATA, 32'hE7);
    ok = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(posedge PCLK); #1;
      if (tog >= 5) begin
        ok = 1'b1;
        break;
      end
    end
    chk("abort_reach_edge5", {31'b0, ok}, 32'd1);
    chk("abort_pre_sclk", {31'b0, SCLK}, 32'd1);
    PRESETn = 1'b0;
    #1;
    chk("abort_sclk", {31'b0, SCLK}, 32'd0);
    chk("abort_ssn", {30'b0, SSn}, 32'd3);
    rd_chk("abort_status", A_STAT, 32'h0A);
    @(posedge PCLK); #1 PRESETn = 1'b1;
    rd_chk("abort_rx_empty", A_DATA, 32'h0);
    apb_wr(A_CFG, 32'h0001_0000);
    apb_wr(A_CTRL, 32'h0000_0101);
    apb_wr(A_DATA, 32'h5C);
    wait_idle("abort_idle");
    rd_chk("abort_rx", A_DATA, 32'h5C);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
